// File: rtl/ofs_plat_prim_uid_multi_if.sv
// Bundle of the allocation and retire signals between several tag consumers
// and the shared multi-channel UID allocator.
interface ofs_plat_prim_uid_multi_if #(
  parameter int N_ENTRIES  = 32,
  parameter int N_CHANNELS = 2
);
  localparam int UID_W = $clog2(N_ENTRIES);
  localparam int NB_W  = $clog2(N_ENTRIES + 1);

  logic [N_CHANNELS-1:0]            alloc;
  logic [N_CHANNELS-1:0]            alloc_ready;
  logic [N_CHANNELS-1:0][UID_W-1:0] alloc_uid;
  logic                             free;
  logic [UID_W-1:0]                 free_uid;
  logic                             free_error;
  logic [NB_W-1:0]                  n_busy;

  modport master (
    output alloc, free, free_uid,
    input  alloc_ready, alloc_uid, free_error, n_busy
  );

  modport slave (
    input  alloc, free, free_uid,
    output alloc_ready, alloc_uid, free_error, n_busy
  );
endinterface

// File: rtl/ofs_plat_prim_uid_multi.sv
// Shared pool of transaction UIDs handed round-robin to several channels, with a
// per-channel ownership cap and detection of frees of idle or reserved UIDs.
module ofs_plat_prim_uid_multi #(
  parameter int N_ENTRIES       = 32,
  parameter int N_RESERVED      = 0,
  parameter int N_CHANNELS      = 2,
  parameter int MAX_PER_CHANNEL = N_ENTRIES
) (
  input  logic                         clk,
  input  logic                         reset,
  ofs_plat_prim_uid_multi_if.slave     uid_if
);
  localparam int UID_W = $clog2(N_ENTRIES);
  localparam int CH_W  = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1;
  localparam int CNT_W = $clog2(MAX_PER_CHANNEL + 1);
  localparam int NB_W  = $clog2(N_ENTRIES + 1);

  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(MAX_PER_CHANNEL);
  localparam logic [UID_W:0]   UID_FIRST = (UID_W + 1)'(N_RESERVED);
  localparam logic [UID_W:0]   UID_LIMIT = (UID_W + 1)'(N_ENTRIES);
  localparam logic [CH_W-1:0]  CH_LAST   = CH_W'(N_CHANNELS - 1);

  logic [N_ENTRIES-1:0]             busy_r;
  logic [CH_W-1:0]                  owner_r [N_ENTRIES];
  logic [CNT_W-1:0]                 cnt_r   [N_CHANNELS];
  logic [N_CHANNELS-1:0]            valid_r;
  logic [N_CHANNELS-1:0][UID_W-1:0] uid_r;
  logic [CH_W-1:0]                  rr_r;
  logic                             free_error_r;
  logic [NB_W-1:0]                  n_busy_r;

  logic                  free_legal_s;
  logic [CH_W-1:0]       free_owner_s;
  logic [N_CHANNELS-1:0] consume_s;
  logic [N_CHANNELS-1:0] stage_freed_s;
  logic [N_CHANNELS-1:0] eligible_s;
  logic [UID_W-1:0]      cand_s;
  logic                  cand_found_s;
  logic                  grant_s;
  logic [CH_W-1:0]       grant_ch_s;
  int                    rr_idx_s;

  // Legality and owner lookup of the UID being retired this cycle.
  always_comb begin
    free_legal_s = 1'b0;
    free_owner_s = {CH_W{1'b0}};
    if (uid_if.free && ({1'b0, uid_if.free_uid} >= UID_FIRST) &&
        ({1'b0, uid_if.free_uid} < UID_LIMIT)) begin
      free_legal_s = busy_r[uid_if.free_uid];
      free_owner_s = owner_r[uid_if.free_uid];
    end else begin
      free_legal_s = 1'b0;
    end
  end

  // Per-channel consume, staged-UID retirement and refill eligibility.
  // A legal free owned by the channel lifts its cap in the same cycle.
  always_comb begin
    consume_s     = {N_CHANNELS{1'b0}};
    stage_freed_s = {N_CHANNELS{1'b0}};
    eligible_s    = {N_CHANNELS{1'b0}};
    for (int c = 0; c < N_CHANNELS; c++) begin
      consume_s[c]     = uid_if.alloc[c] & valid_r[c];
      stage_freed_s[c] = free_legal_s & valid_r[c] & (uid_r[c] == uid_if.free_uid);
      eligible_s[c]    = (!valid_r[c] || consume_s[c]) &&
                         ((cnt_r[c] < CNT_MAX) ||
                          (free_legal_s && (free_owner_s == CH_W'(c))));
    end
  end

  // Lowest idle non-reserved UID, searched in the pre-edge busy vector.
  always_comb begin
    cand_s       = {UID_W{1'b0}};
    cand_found_s = 1'b0;
    for (int i = N_ENTRIES - 1; i >= N_RESERVED; i--) begin
      if (!busy_r[i]) begin
        cand_s       = UID_W'(i);
        cand_found_s = 1'b1;
      end else begin
        cand_found_s = cand_found_s;
      end
    end
  end

  // Round-robin pick of the first eligible channel at or after rr.
  always_comb begin
    grant_s    = 1'b0;
    grant_ch_s = {CH_W{1'b0}};
    rr_idx_s   = 0;
    for (int k = 0; k < N_CHANNELS; k++) begin
      rr_idx_s = int'(rr_r) + k;
      if (rr_idx_s >= N_CHANNELS) begin
        rr_idx_s = rr_idx_s - N_CHANNELS;
      end else begin
        rr_idx_s = rr_idx_s;
      end
      if (!grant_s && cand_found_s && eligible_s[rr_idx_s]) begin
        grant_s    = 1'b1;
        grant_ch_s = CH_W'(rr_idx_s);
      end else begin
        grant_s = grant_s;
      end
    end
  end

  // Pool occupancy and ownership.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_r <= {N_ENTRIES{1'b0}};
      for (int i = 0; i < N_ENTRIES; i++) owner_r[i] <= {CH_W{1'b0}};
    end else begin
      if (free_legal_s) busy_r[uid_if.free_uid] <= 1'b0;
      if (grant_s) begin
        busy_r[cand_s]  <= 1'b1;
        owner_r[cand_s] <= grant_ch_s;
      end
    end
  end

  // Per-channel staging registers and ownership counts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_r <= {N_CHANNELS{1'b0}};
      uid_r   <= '0;
      for (int c = 0; c < N_CHANNELS; c++) cnt_r[c] <= {CNT_W{1'b0}};
    end else begin
      for (int c = 0; c < N_CHANNELS; c++) begin
        if (grant_s && (grant_ch_s == CH_W'(c))) begin
          valid_r[c] <= 1'b1;
          uid_r[c]   <= cand_s;
        end else if (consume_s[c] || stage_freed_s[c]) begin
          valid_r[c] <= 1'b0;
        end
        case ({grant_s && (grant_ch_s == CH_W'(c)),
               free_legal_s && (free_owner_s == CH_W'(c))})
          2'b10:   cnt_r[c] <= cnt_r[c] + CNT_W'(1);
          2'b01:   cnt_r[c] <= cnt_r[c] - CNT_W'(1);
          default: cnt_r[c] <= cnt_r[c];
        endcase
      end
    end
  end

  // Arbitration pointer, busy count and illegal-free pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_r         <= {CH_W{1'b0}};
      n_busy_r     <= {NB_W{1'b0}};
      free_error_r <= 1'b0;
    end else begin
      if (grant_s) rr_r <= (grant_ch_s == CH_LAST) ? {CH_W{1'b0}} : grant_ch_s + CH_W'(1);
      case ({grant_s, free_legal_s})
        2'b10:   n_busy_r <= n_busy_r + NB_W'(1);
        2'b01:   n_busy_r <= n_busy_r - NB_W'(1);
        default: n_busy_r <= n_busy_r;
      endcase
      free_error_r <= uid_if.free & ~free_legal_s;
    end
  end

  assign uid_if.alloc_ready = valid_r;
  assign uid_if.alloc_uid   = uid_r;
  assign uid_if.free_error  = free_error_r;
  assign uid_if.n_busy      = n_busy_r;
endmodule

// File: tb/tb_ofs_plat_prim_uid_multi.sv
// Directed bench for the multi-channel UID allocator: a capped 32-entry pool
// with reserved UIDs and a small uncapped 8-entry pool for exhaustion.
module tb_ofs_plat_prim_uid_multi;
  logic clk;
  logic reset;
  int   tests;
  int   fails;

  ofs_plat_prim_uid_multi_if #(.N_ENTRIES(32), .N_CHANNELS(2)) ifa ();
  ofs_plat_prim_uid_multi_if #(.N_ENTRIES(8),  .N_CHANNELS(2)) ifb ();

  ofs_plat_prim_uid_multi #(
    .N_ENTRIES(32), .N_RESERVED(2), .N_CHANNELS(2), .MAX_PER_CHANNEL(4)
  ) dut_a (
    .clk    (clk),
    .reset  (reset),
    .uid_if (ifa.slave)
  );

  ofs_plat_prim_uid_multi #(
    .N_ENTRIES(8), .N_RESERVED(0), .N_CHANNELS(2), .MAX_PER_CHANNEL(8)
  ) dut_b (
    .clk    (clk),
    .reset  (reset),
    .uid_if (ifb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b1;
    ifa.alloc = 2'b00; ifa.free = 1'b0; ifa.free_uid = 5'd0;
    ifb.alloc = 2'b00; ifb.free = 1'b0; ifb.free_uid = 3'd0;

    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_a_ready", ifa.alloc_ready, 32'd0);
    chk("rst_a_uid0",  ifa.alloc_uid[0], 32'd0);
    chk("rst_a_uid1",  ifa.alloc_uid[1], 32'd0);
    chk("rst_a_err",   ifa.free_error, 32'd0);
    chk("rst_a_nbusy", ifa.n_busy, 32'd0);
    chk("rst_b_nbusy", ifb.n_busy, 32'd0);
    #5 reset = 1'b0;

    // Reset release: channel 0 then channel 1 are staged
    step();
    chk("e1_a_ready", ifa.alloc_ready, 32'd1);
    chk("e1_a_uid0",  ifa.alloc_uid[0], 32'd2);
    chk("e1_a_nbusy", ifa.n_busy, 32'd1);
    chk("e1_b_uid0",  ifb.alloc_uid[0], 32'd0);
    step();
    chk("e2_a_ready", ifa.alloc_ready, 32'd3);
    chk("e2_a_uid1",  ifa.alloc_uid[1], 32'd3);
    chk("e2_a_nbusy", ifa.n_busy, 32'd2);
    chk("e2_b_uid1",  ifb.alloc_uid[1], 32'd1);
    chk("e2_b_nbusy", ifb.n_busy, 32'd2);

    // Channel 0 consumes every cycle until its cap of 4 (2,4,5,6)
    ifa.alloc = 2'b01;
    step();
    chk("b2b_uid4", ifa.alloc_uid[0], 32'd4);
    step();
    chk("b2b_uid5", ifa.alloc_uid[0], 32'd5);
    step();
    chk("b2b_uid6", ifa.alloc_uid[0], 32'd6);
    chk("b2b_nbusy5", ifa.n_busy, 32'd5);
    step();
    chk("cap_ready", ifa.alloc_ready, 32'd2);
    chk("cap_nbusy", ifa.n_busy, 32'd5);

    // Free of UID 4 (owned by ch0) lifts the cap in the same cycle
    ifa.alloc = 2'b00; ifa.free = 1'b1; ifa.free_uid = 5'd4;
    step();
    chk("uncap_ready", ifa.alloc_ready, 32'd3);
    chk("uncap_uid0",  ifa.alloc_uid[0], 32'd7);
    chk("uncap_nbusy", ifa.n_busy, 32'd5);

    // UID 4 freed on the previous edge is granted to ch1 now
    ifa.free = 1'b0; ifa.alloc = 2'b10;
    step();
    chk("reuse_uid1",  ifa.alloc_uid[1], 32'd4);
    chk("reuse_nbusy", ifa.n_busy, 32'd6);

    // Same-cycle free of UID 4 (ch1) and refill of ch1: 4 is not the candidate
    ifa.free = 1'b1; ifa.free_uid = 5'd4;
    step();
    chk("same_uid1",  ifa.alloc_uid[1], 32'd8);
    chk("same_nbusy", ifa.n_busy, 32'd6);
    chk("same_err",   ifa.free_error, 32'd0);
    ifa.free = 1'b0;
    step();
    chk("next_uid1",  ifa.alloc_uid[1], 32'd4);
    chk("next_nbusy", ifa.n_busy, 32'd7);
    step();
    chk("cnt1_ready", ifa.alloc_ready, 32'd3);
    chk("cnt1_uid1",  ifa.alloc_uid[1], 32'd9);
    step();
    chk("cnt1_cap",   ifa.alloc_ready, 32'd1);
    chk("cnt1_nbusy", ifa.n_busy, 32'd8);

    // Illegal frees: reserved UID 1, then idle UID 20
    ifa.alloc = 2'b00; ifa.free = 1'b1; ifa.free_uid = 5'd1;
    step();
    chk("ill_rsv_err",   ifa.free_error, 32'd1);
    chk("ill_rsv_nbusy", ifa.n_busy, 32'd8);
    ifa.free = 1'b0;
    step();
    chk("ill_rsv_pulse", ifa.free_error, 32'd0);
    ifa.free = 1'b1; ifa.free_uid = 5'd20;
    step();
    chk("ill_idle_err", ifa.free_error, 32'd1);
    ifa.free = 1'b0;
    step();
    chk("ill_idle_pulse", ifa.free_error, 32'd0);
    chk("ill_nbusy",      ifa.n_busy, 32'd8);
    chk("ill_ready",      ifa.alloc_ready, 32'd1);
    chk("ill_uid0",       ifa.alloc_uid[0], 32'd7);

    // Exhaust the 8-entry pool with both channels consuming
    ifb.alloc = 2'b11;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("exh_nbusy", ifb.n_busy, 32'(3 + i));
    end
    chk("exh_uid1",  ifb.alloc_uid[1], 32'd7);
    chk("exh_ready", ifb.alloc_ready, 32'd2);
    ifb.alloc = 2'b00;
    step();
    chk("exh_hold_ready", ifb.alloc_ready, 32'd2);
    chk("exh_hold_nbusy", ifb.n_busy, 32'd8);
    ifb.free = 1'b1; ifb.free_uid = 3'd5;
    step();
    chk("exh_free_ready", ifb.alloc_ready, 32'd2);
    chk("exh_free_nbusy", ifb.n_busy, 32'd7);
    ifb.free = 1'b0;
    step();
    chk("exh_regrant_ready", ifb.alloc_ready, 32'd3);
    chk("exh_regrant_uid0",  ifb.alloc_uid[0], 32'd5);
    chk("exh_regrant_nbusy", ifb.n_busy, 32'd8);

    // Asynchronous reset mid-traffic, checked before the next clock edge
    ifa.alloc = 2'b01;
    #3 reset = 1'b1;
    #1;
    chk("arst_a_ready", ifa.alloc_ready, 32'd0);
    chk("arst_a_uid0",  ifa.alloc_uid[0], 32'd0);
    chk("arst_a_uid1",  ifa.alloc_uid[1], 32'd0);
    chk("arst_a_nbusy", ifa.n_busy, 32'd0);
    chk("arst_b_ready", ifb.alloc_ready, 32'd0);
    chk("arst_b_nbusy", ifb.n_busy, 32'd0);
    ifa.alloc = 2'b00;
    #2 reset = 1'b0;
    step();
    chk("rel_a_ready", ifa.alloc_ready, 32'd1);
    chk("rel_a_uid0",  ifa.alloc_uid[0], 32'd2);
    chk("rel_a_nbusy", ifa.n_busy, 32'd1);
    chk("rel_b_uid0",  ifb.alloc_uid[0], 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
